// File: rtl/vfadd16_pkg.sv
// Shared constants, stage payload type and packing helper for the multi-lane FP16 adder.
package vfadd16_pkg;

  localparam int unsigned EXP_W  = 5;
  localparam int unsigned FRAC_W = 10;
  localparam int unsigned EXT_W  = 15;
  localparam logic [EXP_W-1:0] EXP_MAX = 5'h1F;
  localparam logic [EXP_W-1:0] EXP_SAT = 5'h1E;

  // Extended mantissa layout: {carry, hidden, frac[9:0], G, R, S}
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [EXT_W-1:0]  man;
    logic              special;
  } stage_t;

  function automatic logic [15:0] fp16_pack(input logic sign,
                                            input logic [EXP_W-1:0] exp,
                                            input logic [FRAC_W-1:0] frac);
    return {sign, exp, frac};
  endfunction

endpackage

// File: rtl/vfadd16_lane.sv
// Single-lane FP16 add/sub datapath: align, add, normalise/round; all stages share one advance enable.
module vfadd16_lane
  import vfadd16_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Advance,
  input  logic        Sub,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] Sum,
  output logic        Overflow
);

  // Right shift that folds every shifted-out bit into the sticky position.
  function automatic logic [EXT_W-1:0] align_shr(input logic [EXT_W-1:0] m,
                                                 input logic [EXP_W-1:0] d);
    logic [EXT_W-1:0] shifted;
    logic [EXT_W-1:0] lost;
    shifted = m >> d;
    lost    = m & ~({EXT_W{1'b1}} << d);
    if (d >= 5'd14) begin
      return {{(EXT_W-1){1'b0}}, |m};
    end
    return {shifted[EXT_W-1:1], shifted[0] | (|lost)};
  endfunction

  logic             a_spec, b_spec, b_sign, a_big;
  logic [EXP_W-1:0] ea, eb, ediff;
  logic [EXT_W-1:0] ma, mb;

  stage_t           s1_a_n, s1_a;
  logic             s1_b_sign_n, s1_b_sign;
  logic [EXT_W-1:0] s1_b_man_n, s1_b_man;
  stage_t           s2_n, s2;

  logic [EXT_W-1:0]  m;
  logic [5:0]        e, e_fin;
  logic [11:0]       rnd;
  logic [FRAC_W-1:0] frac;
  logic              rup, ovf_n;
  logic [15:0]       sum_n;

  // S1: expand, pick common exponent, align the smaller operand
  always_comb begin
    a_spec = (A[14:10] == EXP_MAX);
    b_spec = (B[14:10] == EXP_MAX);
    b_sign = B[15] ^ Sub;
    ea     = (A[14:10] == '0) ? 5'd1 : A[14:10];
    eb     = (B[14:10] == '0) ? 5'd1 : B[14:10];
    ma     = {1'b0, (A[14:10] != '0), A[9:0], 3'b000};
    mb     = {1'b0, (B[14:10] != '0), B[9:0], 3'b000};
    a_big  = (ea >= eb);
    ediff  = a_big ? (ea - eb) : (eb - ea);

    s1_a_n         = '0;
    s1_a_n.sign    = A[15];
    s1_a_n.exp     = a_big ? ea : eb;
    s1_a_n.man     = a_big ? ma : align_shr(ma, ediff);
    s1_a_n.special = a_spec | b_spec;
    if (!a_spec && b_spec) begin
      s1_a_n.sign = b_sign;
    end
    s1_b_sign_n = b_sign;
    s1_b_man_n  = a_big ? align_shr(mb, ediff) : mb;
  end

  // S2: magnitude add or subtract; exact cancellation yields +0
  always_comb begin
    s2_n         = '0;
    s2_n.exp     = s1_a.exp;
    s2_n.special = s1_a.special;
    s2_n.sign    = s1_a.sign;
    if (s1_a.special) begin
      s2_n.man = '0;
    end else if (s1_a.sign == s1_b_sign) begin
      s2_n.man = s1_a.man + s1_b_man;
    end else if (s1_a.man >= s1_b_man) begin
      s2_n.man  = s1_a.man - s1_b_man;
      s2_n.sign = (s1_a.man == s1_b_man) ? 1'b0 : s1_a.sign;
    end else begin
      s2_n.man  = s1_b_man - s1_a.man;
      s2_n.sign = s1_b_sign;
    end
  end

  // S3: normalise, round to nearest even, saturate on exponent overflow
  always_comb begin
    m = s2.man;
    e = {1'b0, s2.exp};
    if (m[14]) begin
      m = {1'b0, m[14:2], m[1] | m[0]};
      e = e + 6'd1;
    end else begin
      for (int unsigned i = 0; i < 13; i++) begin
        if (!m[13] && (e > 6'd1)) begin
          m = m << 1;
          e = e - 6'd1;
        end
      end
    end

    rup = m[2] & (m[1] | m[0] | m[3]);
    rnd = {1'b0, m[13:3]} + {11'd0, rup};
    if (rnd[11]) begin
      e_fin = e + 6'd1;
      frac  = '0;
    end else if (rnd[10]) begin
      e_fin = e;
      frac  = rnd[9:0];
    end else begin
      e_fin = '0;
      frac  = rnd[9:0];
    end

    ovf_n = s2.special | (e_fin > {1'b0, EXP_SAT});
    sum_n = ovf_n ? fp16_pack(s2.sign, EXP_MAX, '0)
                  : fp16_pack(s2.sign, e_fin[4:0], frac);
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      s1_a      <= '0;
      s1_b_sign <= 1'b0;
      s1_b_man  <= '0;
      s2        <= '0;
      Sum       <= '0;
      Overflow  <= 1'b0;
    end else if (Advance) begin
      s1_a      <= s1_a_n;
      s1_b_sign <= s1_b_sign_n;
      s1_b_man  <= s1_b_man_n;
      s2        <= s2_n;
      Sum       <= sum_n;
      Overflow  <= ovf_n;
    end
  end

endmodule

// File: rtl/vfadd16_pipe.sv
// LANES-wide FP16 adder, 3-stage pipeline with valid/ready handshake and per-lane sticky overflow.
module vfadd16_pipe
  import vfadd16_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned W     = 16
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               In_valid,
  output logic               In_ready,
  input  logic               Sub,
  input  logic [LANES*W-1:0] A,
  input  logic [LANES*W-1:0] B,
  output logic               Out_valid,
  input  logic               Out_ready,
  output logic [LANES*W-1:0] Sum,
  output logic [LANES-1:0]   Overflow,
  output logic [LANES-1:0]   Ovf_sticky,
  input  logic               Clr_sticky
);

  logic v1, v2, v3;
  logic advance;

  // Whole pipeline moves together; bubbles are held, never squeezed out.
  assign advance   = ~v3 | Out_ready;
  assign In_ready  = advance;
  assign Out_valid = v3;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else if (advance) begin
      v1 <= In_valid;
      v2 <= v1;
      v3 <= v2;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      Ovf_sticky <= '0;
    end else if (Clr_sticky) begin
      Ovf_sticky <= '0;
    end else if (v3 && Out_ready) begin
      Ovf_sticky <= Ovf_sticky | Overflow;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    vfadd16_lane u_lane (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .Advance  (advance),
      .Sub      (Sub),
      .A        (A[i*W +: W]),
      .B        (B[i*W +: W]),
      .Sum      (Sum[i*W +: W]),
      .Overflow (Overflow[i])
    );
  end

endmodule
